mdu_ctrl: RTL

- Multiply/divide sequencing controller for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo commands and owns the HI/LO registers.
- Models the fixed multi-cycle latency with a busy counter.
- Generates the stall that holds any later MD-class instruction in D until the unit is free.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_arith.sv | 61 ++++++
 rtl/mdu_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op-code constants, state encoding, default latencies and small
// op-class helpers shared by the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_DATA_W      = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_RSVD  = 3'd7;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Commands that occupy the unit for several cycles (mult/multu/div/divu).
  function automatic logic mdu_is_multicycle(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//   i_op          command code (mdu_pkg op constants)
//   i_rs_val      first operand / dividend
//   i_rt_val      second operand / divisor
//   o_result      {hi, lo}: product, or {remainder, quotient} for divides
//   o_div_by_zero divide command with a zero divisor
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic [2:0]          i_op,
  input  logic [DATA_W-1:0]   i_rs_val,
  input  logic [DATA_W-1:0]   i_rt_val,
  output logic [2*DATA_W-1:0] o_result,
  output logic                o_div_by_zero
);

  logic signed [2*DATA_W-1:0] w_sa, w_sb, w_sprod;
  logic        [2*DATA_W-1:0] w_uprod;
  logic                       w_neg_a, w_neg_b;
  logic        [DATA_W-1:0]   w_mag_a, w_mag_b, w_den_s, w_den_u;
  logic        [DATA_W-1:0]   w_qmag, w_rmag, w_sq, w_sr, w_uq, w_ur;

  assign w_sa    = {{DATA_W{i_rs_val[DATA_W-1]}}, i_rs_val};
  assign w_sb    = {{DATA_W{i_rt_val[DATA_W-1]}}, i_rt_val};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {{DATA_W{1'b0}}, i_rs_val} * {{DATA_W{1'b0}}, i_rt_val};

  // Signed divide done on magnitudes so truncation toward zero and the
  // most-negative / -1 case fall out of plain unsigned arithmetic.
  assign w_neg_a = i_rs_val[DATA_W-1];
  assign w_neg_b = i_rt_val[DATA_W-1];
  assign w_mag_a = w_neg_a ? (-i_rs_val) : i_rs_val;
  assign w_mag_b = w_neg_b ? (-i_rt_val) : i_rt_val;

  // Divisor forced to 1 on zero; the result is discarded in that case anyway.
  assign w_den_s = (w_mag_b  == '0) ? DATA_W'(1) : w_mag_b;
  assign w_den_u = (i_rt_val == '0) ? DATA_W'(1) : i_rt_val;

  assign w_qmag = w_mag_a / w_den_s;
  assign w_rmag = w_mag_a % w_den_s;
  assign w_sq   = (w_neg_a ^ w_neg_b) ? (-w_qmag) : w_qmag;
  assign w_sr   = w_neg_a ? (-w_rmag) : w_rmag;
  assign w_uq   = i_rs_val / w_den_u;
  assign w_ur   = i_rs_val % w_den_u;

  always_comb begin
    o_result = '0;
    case (i_op)
      MDU_MULT:  o_result = w_sprod;
      MDU_MULTU: o_result = w_uprod;
      MDU_DIV:   o_result = {w_sr, w_sq};
      MDU_DIVU:  o_result = {w_ur, w_uq};
      default:   o_result = '0;
    endcase
  end

  assign o_div_by_zero = mdu_is_div(i_op) && (i_rt_val == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO.
//   clk, reset          clock, async active-high reset
//   start, op           E-stage command valid and command code
//   rs_val, rt_val      forwarded operands
//   d_is_md             D-stage instruction is an MD-class instruction
//   busy                multi-cycle operation in progress
//   hi, lo              architectural HI/LO registers
//   md_stall            hold the D-stage MD instruction
//
//   state | meaning
//   IDLE  | accepts commands; mthi/mtlo write directly
//   RUN   | counting down latency; result held in pending
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W      = MDU_DATA_W,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              d_is_md,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              md_stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_pend_hi, r_pend_lo;
  logic                r_pend_wr;
  logic                r_busy;
  logic [DATA_W-1:0]   r_hi, r_lo;

  logic [2*DATA_W-1:0] w_result;
  logic                w_div_by_zero;
  logic                w_md_cmd;

  mdu_arith #(.DATA_W(DATA_W)) u_arith (
    .i_op          (op),
    .i_rs_val      (rs_val),
    .i_rt_val      (rt_val),
    .o_result      (w_result),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_md_cmd = start && mdu_is_multicycle(op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MDU_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (w_md_cmd) begin
            r_pend_hi <= w_result[2*DATA_W-1:DATA_W];
            r_pend_lo <= w_result[DATA_W-1:0];
            // Divide by zero still burns the full latency but never writes.
            r_pend_wr <= !w_div_by_zero;
            r_cnt     <= mdu_is_div(op) ? DIV_LOAD : MULT_LOAD;
            r_busy    <= 1'b1;
            r_state   <= MDU_RUN;
          end else if (start && (op == MDU_MTHI)) begin
            r_hi <= rs_val;
          end else if (start && (op == MDU_MTLO)) begin
            r_lo <= rs_val;
          end
        end
        MDU_RUN: begin
          // Commands arriving here are ignored.
          if (r_cnt == CNT_W'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= MDU_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  // Includes the E cycle of a command, before busy has risen.
  assign md_stall = d_is_md && (r_busy || w_md_cmd);

endmodule
